// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned DATA_W     = NUM_DIGITS * BCD_W;

  localparam logic [0:6]            SEG_BLANK = 7'b1111111;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = 4'b1111;

  typedef logic [1:0]       digit_idx_t;
  typedef logic [BCD_W-1:0] bcd_t;

  // Display payload: four BCD digits plus per-digit decimal points (active-high).
  typedef struct packed {
    logic [DATA_W-1:0]     digits;
    logic [NUM_DIGITS-1:0] dp;
  } disp_t;

  // Extract digit i (0 = rightmost) from a packed four-digit value.
  function automatic bcd_t digit_of(input logic [DATA_W-1:0] digits, input digit_idx_t i);
    return digits[{i, 2'b00} +: BCD_W];
  endfunction

endpackage

// File: rtl/seg_refresh_timer.sv
// Slot counter and digit index for the display scan. All status flags are
// registered and describe the current value of cnt/idx.
module seg_refresh_timer
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       slot_end,
  output logic       frame_wrap,
  output logic       in_blank,
  output logic       blank_end,
  output digit_idx_t idx
);

  localparam int unsigned      CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_N    = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  digit_idx_t       idx_n;

  // Next slot position: wrap cnt at slot end and advance the digit.
  always_comb begin
    cnt_n = cnt + CNT_W'(1);
    idx_n = idx;
    if (cnt == CNT_LAST) begin
      cnt_n = '0;
      idx_n = idx + 2'd1;
    end
  end

  // Counters plus flags precomputed from the next position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      slot_end   <= 1'b0;
      frame_wrap <= 1'b0;
      in_blank   <= 1'b1;
      blank_end  <= (BLANK_LAST == '0);
    end else begin
      cnt        <= cnt_n;
      idx        <= idx_n;
      slot_end   <= (cnt_n == CNT_LAST);
      frame_wrap <= (cnt_n == CNT_LAST) && (idx_n == 2'd3);
      in_blank   <= (cnt_n < BLANK_N);
      blank_end  <= (cnt_n == BLANK_LAST);
    end
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Four-digit seven-segment scan controller with valid/ready display load and
// frame-aligned commit. Optional leading-zero suppression is enabled with
// the SEG_LEADING_ZERO_BLANK_EN macro.
module seven_segment_scanner
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  input  logic [3:0]  load_dp,
  output logic        load_ready,
  output logic [3:0]  bcd,
  input  logic [0:6]  seg_in,
  output logic [0:6]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_start
);

  logic       slot_end;
  logic       frame_wrap;
  logic       in_blank;
  logic       blank_end;
  digit_idx_t idx;

  seg_refresh_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .slot_end   (slot_end),
    .frame_wrap (frame_wrap),
    .in_blank   (in_blank),
    .blank_end  (blank_end),
    .idx        (idx)
  );

  disp_t     disp, disp_n;
  disp_t     pend, pend_n;
  logic      pending, pending_n;
  logic      drive_q, drive_n;
  bcd_t      bcd_n;
  logic [3:0] an_n;
  logic      dp_n;
  logic      accept;
  logic      commit;
  logic      suppress;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Hide digit idx when it and every digit above it are zero and its dp is off.
  always_comb begin
    suppress = 1'b0;
    case (idx)
      2'd1:    suppress = (disp.digits[15:4]  == '0) && !disp.dp[1];
      2'd2:    suppress = (disp.digits[15:8]  == '0) && !disp.dp[2];
      2'd3:    suppress = (disp.digits[15:12] == '0) && !disp.dp[3];
      default: suppress = 1'b0;
    endcase
  end
`else
  assign suppress = 1'b0;
`endif

  // Next state: handshake, frame commit, decoder feed and next-cycle drive.
  // Drive never begins on a slot boundary, so idx is already the next-cycle digit.
  always_comb begin
    disp_n    = disp;
    pend_n    = pend;
    pending_n = pending;
    bcd_n     = bcd;
    an_n      = AN_OFF;
    dp_n      = 1'b1;
    drive_n   = 1'b0;
    accept    = load_valid & load_ready;
    commit    = frame_wrap & pending;

    if (accept) begin
      pend_n.digits = load_data;
      pend_n.dp     = load_dp;
      pending_n     = 1'b1;
    end
    if (commit) begin
      disp_n    = pend;
      pending_n = 1'b0;
    end

    if (slot_end) begin
      bcd_n = digit_of(disp_n.digits, idx + 2'd1);
    end

    drive_n = !slot_end && (!in_blank || blank_end) && !suppress;
    if (drive_n) begin
      an_n = ~(NUM_DIGITS'(1) << idx);
      dp_n = ~disp.dp[idx];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp       <= '0;
      pend       <= '0;
      pending    <= 1'b0;
      load_ready <= 1'b1;
      bcd        <= '0;
      an         <= AN_OFF;
      dp         <= 1'b1;
      drive_q    <= 1'b0;
    end else begin
      disp       <= disp_n;
      pend       <= pend_n;
      pending    <= pending_n;
      load_ready <= ~pending_n;
      bcd        <= bcd_n;
      an         <= an_n;
      dp         <= dp_n;
      drive_q    <= drive_n;
    end
  end

  // Segments pass the registered decoder result straight through while driving,
  // so a single blank cycle is enough to hide decoder latency.
  assign seg         = drive_q ? seg_in : SEG_BLANK;
  assign frame_start = frame_wrap;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner: random loads, a frame-level
// display model and a scoreboard of accepted loads awaiting commit.
module tb_seven_segment_scanner;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_valid;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic        load_ready;
  logic [3:0]  bcd;
  logic [0:6]  seg_in;
  logic [0:6]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  seven_segment_scanner #(
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_dp     (load_dp),
    .load_ready  (load_ready),
    .bcd         (bcd),
    .seg_in      (seg_in),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  p;
    int          acc;
  } item_t;

  item_t       exp_q[$];
  logic [15:0] cur;
  logic [3:0]  cur_dp;
  int          t;
  int          total = 0;
  int          bad = 0;

  function automatic logic [0:6] dec(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  // Registered external decoder, one cycle of latency.
  always @(posedge clk) seg_in <= dec(bcd);

  // Cycle count since reset release; cycle 0 is the first slot's first cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else        t <= t + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", nm, t, act, exp);
    end
  endtask

  // Monitor: every cycle the display is compared with the frame-level model.
  always @(negedge clk) begin
    int         slot;
    int         ph;
    int         dg;
    logic       blank;
    logic       wrap;
    logic [3:0] e_an;
    logic [0:6] e_seg;
    logic       e_dp;
    if (!rst_n) begin
      cur    = '0;
      cur_dp = '0;
      exp_q.delete();
    end else begin
      slot  = (t / DIV) % 4;
      ph    = t % DIV;
      wrap  = (ph == DIV - 1) && (slot == 3);
      dg    = int'((cur >> (4 * slot)) & 16'hF);
      blank = (ph < BLANK);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (slot > 0 && (cur >> (4 * slot)) == 16'h0 && cur_dp[slot] == 1'b0) blank = 1'b1;
`endif
      e_an  = blank ? 4'hF : 4'(15 - (1 << slot));
      e_seg = blank ? 7'b1111111 : dec(4'(dg));
      e_dp  = blank ? 1'b1 : ~cur_dp[slot];
      chk("an", 32'(an), 32'(e_an));
      chk("seg", 32'(seg), 32'(e_seg));
      chk("dp", 32'(dp), 32'(e_dp));
      chk("bcd", 32'(bcd), 32'(dg));
      chk("frame_start", 32'(frame_start), 32'(wrap));
      chk("load_ready", 32'(load_ready), 32'(exp_q.size() == 0));
      if (wrap && exp_q.size() > 0 && exp_q[0].acc < t) begin
        cur    = exp_q[0].d;
        cur_dp = exp_q[0].p;
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic chk_reset();
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_ready", 32'(load_ready), 32'h1);
    chk("rst_frame_start", 32'(frame_start), 32'h0);
    chk("rst_bcd", 32'(bcd), 32'h0);
  endtask

  // Offer a value and hold it until accepted; push the accepted item to the scoreboard.
  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    bit ok;
    int acc;
    ok  = 1'b0;
    acc = 0;
    load_data  = d;
    load_dp    = p;
    load_valid = 1'b1;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (load_ready === 1'b1) begin
        ok  = 1'b1;
        acc = t;
      end
      @(posedge clk);
    end
    if (ok) begin
      exp_q.push_back('{d: d, p: p, acc: acc});
    end else begin
      total++;
      bad++;
      $display("FAIL load_accept_timeout actual=no_transfer required=transfer");
    end
    #1;
    load_valid = 1'b0;
    load_data  = 16'($urandom);
    load_dp    = 4'($urandom);
  endtask

  task automatic wait_mod(input int target);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 4 * FRAME && !hit; n++) begin
      @(posedge clk);
      #1;
      if (t % FRAME == target) hit = 1'b1;
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL wait_phase actual=unreached required=%0d", target);
    end
  endtask

  task automatic wait_empty();
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 10 * FRAME && !hit; n++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) hit = 1'b1;
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL commit_timeout actual=pending required=committed");
    end
  endtask

  initial begin
    logic [15:0] rd;
    load_valid = 1'b0;
    load_data  = '0;
    load_dp    = '0;
    #1 rst_n = 1'b0;
    #2 chk_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Idle display of 0000
    repeat (2 * FRAME + 6) @(posedge clk);
    #1;

    // Mid-frame load, then a second load held off while the first is pending
    wait_mod(12);
    do_load(16'h1234, 4'b0100);
    do_load(16'h9087, 4'b1001);
    wait_empty();
    repeat (FRAME + 4) @(posedge clk);
    #1;

    // Load accepted on the wrap cycle commits one frame later
    wait_mod(FRAME - 1);
    do_load(16'h4321, 4'b0001);
    repeat (2 * FRAME + 4) @(posedge clk);
    #1;

    // Leading zeros, plus non-BCD digit values
    do_load(16'h0070, 4'b0000);
    wait_empty();
    repeat (FRAME + 2) @(posedge clk);
    #1;
    do_load(16'hAFBC, 4'b0010);
    wait_empty();
    repeat (FRAME + 2) @(posedge clk);
    #1;

    // Reset during DRIVE with a load pending
    wait_empty();
    wait_mod(3);
    do_load(16'h5678, 4'b1111);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (FRAME + 4) @(posedge clk);
    #1;

    // Randomized loads
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #1;
      rd = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rd = rd & 16'h00FF;
      do_load(rd, 4'($urandom_range(0, 15)));
    end
    wait_empty();
    repeat (2 * FRAME + 2) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexed scan controller for the four-digit Basys3 seven-segment display. It holds a 4-digit BCD display value loaded by upstream logic (UART receive path) through a valid/ready handshake. It sequences the shared, registered BCD-to-seven-segment decoder one digit at a time and drives the active-low anodes, segments and decimal point, with an anti-ghosting blanking gap at every digit change.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot (1 kHz digit rate at 100 MHz); must exceed BLANK_CYCLES.
- BLANK_CYCLES, 2: cycles at the start of each slot with all anodes off; must be ≥1 to cover decoder latency.
- clk  input  1  system clock.
- rst_n  input  1  reset; one clock, asynchronous, active-low.
- load_valid  input  1  upstream has a new display value.
- load_data  input  16  four BCD digits; [3:0] = digit 0 (rightmost, an[0]) … [15:12] = digit 3.
- load_dp  input  4  decimal point per digit, active-high, captured with load_data.
- load_ready  output  1  high when a load can be accepted.
- bcd  output  4  digit value to the shared decoder.
- seg_in  input  [0:6]  decoder result, segments a..g, active-low, valid one cycle after bcd.
- seg  output  [0:6]  segment drive, active-low.
- dp  output  1  decimal point drive, active-low.
- an  output  4  anode drive, active-low, one-hot-low while driving.
- frame_start  output  1  one-cycle pulse at each digit 3→0 wrap.

## Operation
- Registers: slot counter cnt (0..REFRESH_DIV-1), digit index idx (0..3), display value disp/disp_dp, pending value pend/pend_dp, pending flag.
- Reset values: cnt=0, idx=0, disp=0, disp_dp=0, pending=0, bcd=0, an=4'b1111, seg=7'b1111111, dp=1, load_ready=1, frame_start=0.
- Two phases per slot, decoded from cnt:
  - BLANK (cnt < BLANK_CYCLES): an=4'b1111, seg=7'b1111111, dp=1.
  - DRIVE (otherwise): an = all ones except bit idx low, seg=seg_in, dp = ~disp_dp[idx].
- Slot end (cnt==REFRESH_DIV-1): cnt→0, idx→idx+1 mod 4, bcd←disp digit of new idx (registered, same edge).
- Frame wrap (idx 3→0): frame_start=1 for that cycle. If pending, disp←pend, disp_dp←pend_dp and pending cleared on the same edge; bcd uses the newly committed value.
- Handshake: load_ready = ~pending. A transfer occurs on a cycle with load_valid & load_ready. pend captures the data and pending sets. The commit happens at the first frame wrap strictly after acceptance. If acceptance coincides with a wrap edge, the commit happens at the next wrap. No partial-frame updates (no tearing).
- Non-BCD digit values (10–15) are passed unchanged to the decoder.
- Reset mid-frame: all state returns to reset values immediately; any pending load is discarded.

## Timing
- bcd changes on the slot-end edge. seg_in is valid one edge later, inside BLANK. an goes low no earlier than BLANK_CYCLES after the bcd change.
- Drive time per slot = REFRESH_DIV − BLANK_CYCLES cycles. Frame period = 4·REFRESH_DIV.
- Load-to-display latency: up to one frame plus BLANK_CYCLES.
- load_ready falls on the edge after acceptance and rises on the edge after commit.

## Configuration
- SEG_LEADING_ZERO_BLANK_EN defined: during DRIVE, digit k (k=3,2,1) is suppressed (an stays 4'b1111, seg=7'b1111111, dp=1) if disp digits k..3 are all zero and disp_dp[k]=0. Digit 0 is never suppressed.
- Undefined: all four digits are always driven.

## Structure
- Package seg_pkg:
  - NUM_DIGITS=4.
  - SEG_BLANK=7'b1111111.
  - AN_OFF=4'b1111.
  - digit index typedef (2-bit).
  - BCD digit typedef (4-bit).
- Sub-module seg_refresh_timer: the cnt/idx counters. Outputs slot_end, frame_wrap, in_blank and idx.
- The decoder is not instantiated here; it is wired alongside at the top level.

## Test plan
All scenarios use REFRESH_DIV=8 and BLANK_CYCLES=2 unless stated.
1. Reset, no load: an cycles 1111 for 2 cycles, then 1110 for 6 cycles, then 1111 for 2 cycles, then 1101, … Bench decoder returns 0000001 for 0, so seg=0000001 in every DRIVE phase.
2. Load 16'h1234 with dp=4'b0100 mid-frame: load_ready drops. Display is unchanged until frame_start. After frame_start the slot order is 4, 3, 2, 1; dp is low only while an=1011; load_ready rises the cycle after commit.
3. Second load_valid while pending: no transfer (load_ready=0). It is accepted after commit and shown one frame later.
4. Load accepted on the frame_start cycle: the value is not shown this frame and is committed at the next frame_start.
5. With SEG_LEADING_ZERO_BLANK_EN, load 16'h0070: an never shows 0111 or 1011 low. Digits 1 and 0 are driven, with seg for 7 and 0.
6. Assert rst_n low during DRIVE with a load pending: an=1111, seg=1111111, load_ready=1 asynchronously. After release, the display shows 0000.
